// File: rtl/fir_inverse_decoder_if.sv
// ---------------------------------------------------------------------------
// fir_inverse_decoder_if
//
// Purpose : groups the sample stream and status signals of the FIR inverse
//           decoder into one bundle. The producer side (the block feeding
//           filtered samples and reading recovered ones) uses 'master'; the
//           decoder itself uses 'slave'.
//
// Signals :
//   y_in     [WORD_SIZE_OUT] filtered sample y[n], unsigned
//   y_valid                  y_in carries a new sample this cycle
//   resync                   clear history and leave FAULT (single-cycle pulse)
//   x_out    [SAMPLE_SIZE]   recovered sample x[n], registered
//   x_valid                  one-cycle pulse per recovered sample
//   err                      sticky decode-fault flag
//   x_count  [16]            saturating count of recovered samples
// ---------------------------------------------------------------------------
interface fir_inverse_decoder_if #(
  parameter int unsigned SAMPLE_SIZE   = 4,
  parameter int unsigned WORD_SIZE_OUT = 12
);

  logic [WORD_SIZE_OUT-1:0] y_in;
  logic                     y_valid;
  logic                     resync;
  logic [SAMPLE_SIZE-1:0]   x_out;
  logic                     x_valid;
  logic                     err;
  logic [15:0]              x_count;

  modport master (
    output y_in,
    output y_valid,
    output resync,
    input  x_out,
    input  x_valid,
    input  err,
    input  x_count
  );

  modport slave (
    input  y_in,
    input  y_valid,
    input  resync,
    output x_out,
    output x_valid,
    output err,
    output x_count
  );

endinterface : fir_inverse_decoder_if

// File: rtl/fir_inverse_decoder.sv
// ---------------------------------------------------------------------------
// fir_inverse_decoder
//
// Purpose : recovers the original sample stream x[n] from the output of a
//           known 7-tap FIR  y[n] = sum_{k=0..6} Bk * x[n-k].
//           Each accepted y is decoded in a single cycle against the six most
//           recently recovered samples:
//             r    = y[n] - sum_{k=1..6} Bk * h[k]
//             x[n] = r / B0
//           A sample whose residual is negative, not a multiple of B0, or
//           whose quotient does not fit SAMPLE_SIZE bits means the stream has
//           lost lock; the block then raises a sticky err and ignores input
//           until resync (or reset).
//
// Ports   :
//   clock  rising-edge clock
//   reset  synchronous, active-high; dominates every other input
//   bus    fir_inverse_decoder_if.slave (y_in, y_valid, resync in;
//          x_out, x_valid, err, x_count out)
//
// Parameters:
//   SAMPLE_SIZE    width of a recovered sample
//   WORD_SIZE_OUT  width of a filtered input word
//   B0..B6         4-bit unsigned filter coefficients; B0 must be nonzero
// ---------------------------------------------------------------------------
module fir_inverse_decoder #(
  parameter int unsigned SAMPLE_SIZE   = 4,
  parameter int unsigned WORD_SIZE_OUT = 12,
  parameter logic [3:0]  B0            = 4'd2,
  parameter logic [3:0]  B1            = 4'd5,
  parameter logic [3:0]  B2            = 4'd9,
  parameter logic [3:0]  B3            = 4'd14,
  parameter logic [3:0]  B4            = 4'd9,
  parameter logic [3:0]  B5            = 4'd5,
  parameter logic [3:0]  B6            = 4'd2
) (
  input  logic                  clock,
  input  logic                  reset,
  fir_inverse_decoder_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Sizing
  // -------------------------------------------------------------------------
  // The tap sum is at most 6 * 15 * (2^SAMPLE_SIZE - 1) < 2^(SAMPLE_SIZE+7).
  // Two extra bits over the wider of the two operands give a sign bit plus
  // headroom, so the subtraction can never wrap.
  localparam int R_W = ((WORD_SIZE_OUT > SAMPLE_SIZE + 7) ?
                        WORD_SIZE_OUT : SAMPLE_SIZE + 7) + 2;

  localparam logic [R_W-1:0] X_MAX  = R_W'((1 << SAMPLE_SIZE) - 1);
  localparam logic [R_W-1:0] DIV_B0 = R_W'(B0);
  localparam logic [15:0]    CNT_MAX = 16'hFFFF;

  // History taps B1..B6, indexed like h[k].
  localparam logic [3:0] COEF [1:6] = '{B1, B2, B3, B4, B5, B6};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_RUN,
    ST_FAULT
  } state_e;

  typedef logic [SAMPLE_SIZE-1:0] sample_t;

  state_e   state_q,   state_d;
  sample_t  hist_q [1:6];
  sample_t  hist_d [1:6];
  sample_t  x_out_q,   x_out_d;
  logic     x_valid_q, x_valid_d;
  logic     err_q,     err_d;
  logic [15:0] x_count_q, x_count_d;

  // -------------------------------------------------------------------------
  // Residual and decode check (single combinational stage)
  // -------------------------------------------------------------------------
  logic [R_W-1:0]        tap_sum;
  logic signed [R_W-1:0] residual;
  logic [R_W-1:0]        res_mag;
  logic [R_W-1:0]        quot;
  logic [R_W-1:0]        rem;
  logic                  decode_ok;

  // NOTE: every variable assigned in an always_comb block gets a value before
  // any conditional logic, so no path can leave it unassigned and infer a latch.
  always_comb begin
    tap_sum = '0;
    for (int k = 1; k <= 6; k++) begin
      tap_sum = tap_sum + R_W'(COEF[k]) * R_W'(hist_q[k]);
    end
  end

  always_comb begin
    residual  = signed'(R_W'(bus.y_in)) - signed'(tap_sum);
    res_mag   = unsigned'(residual);
    // Only meaningful when the residual is non-negative; decode_ok gates it.
    quot      = res_mag / DIV_B0;
    rem       = res_mag % DIV_B0;
    decode_ok = !residual[R_W-1] && (rem == '0) && (quot <= X_MAX);
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    x_out_d   = x_out_q;
    x_valid_d = 1'b0;          // x_valid is a pulse; it only rises on a decode
    err_d     = err_q;
    x_count_d = x_count_q;

    if (bus.resync) begin
      // resync wins over a coincident y_valid; that sample is discarded.
      state_d   = ST_RUN;
      hist_d    = '{default: '0};
      x_out_d   = '0;
      err_d     = 1'b0;
      x_count_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.y_valid) begin
            if (decode_ok) begin
              x_out_d   = quot[SAMPLE_SIZE-1:0];
              x_valid_d = 1'b1;
              hist_d[1] = quot[SAMPLE_SIZE-1:0];
              for (int k = 2; k <= 6; k++) begin
                hist_d[k] = hist_q[k-1];
              end
              if (x_count_q != CNT_MAX) begin
                x_count_d = x_count_q + 16'd1;
              end
            end else begin
              // Lost lock: freeze everything except the fault indication.
              err_d   = 1'b1;
              state_d = ST_FAULT;
            end
          end
        end

        ST_FAULT: begin
          // Input is ignored until resync or reset.
          err_d = 1'b1;
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // History is part of the decoder's arithmetic state, so it is cleared
      // together with the control flops rather than left undefined.
      state_q   <= ST_RUN;
      hist_q    <= '{default: '0};
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      err_q     <= 1'b0;
      x_count_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      err_q     <= err_d;
      x_count_q <= x_count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.x_out   = x_out_q;
  assign bus.x_valid = x_valid_q;
  assign bus.err     = err_q;
  assign bus.x_count = x_count_q;

endmodule : fir_inverse_decoder

// File: doc/fir_inverse_decoder.md
FIR_INVERSE_DECODER -- requirements
Module: fir_inverse_decoder

Interface
REQ-001 Parameter SAMPLE_SIZE, default 4, recovered sample width (unsigned).
REQ-002 Parameter WORD_SIZE_OUT, default 12, width of filtered input word (unsigned).
REQ-003 Parameters B0..B6, defaults 2,5,9,14,9,5,2, 4-bit unsigned filter coefficients; B0 SHALL be nonzero.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 y_in  input  WORD_SIZE_OUT  filtered sample y[n], unsigned.
REQ-007 y_valid  input  1  y_in carries a new sample this cycle.
REQ-008 resync  input  1  clear history and leave FAULT; single-cycle pulse.
REQ-009 x_out  output  SAMPLE_SIZE  recovered sample x[n], registered.
REQ-010 x_valid  output  1  x_out updated this cycle; one-cycle pulse per accepted y.
REQ-011 err  output  1  sticky decode-fault flag, registered.
REQ-012 x_count  output  16  number of samples recovered since reset/resync, saturating at 65535.

Function
REQ-013 Block SHALL invert the 7-tap FIR y[n] = sum_{k=0..6} Bk*x[n-k], recovering x[n] = (y[n] - sum_{k=1..6} Bk*h[k]) / B0, where h[k] = x[n-k].
REQ-014 History h[1..6] SHALL be registers of SAMPLE_SIZE bits holding previously recovered samples, all zero after reset or resync.
REQ-015 Residual r = y_in - sum_{k=1..6} Bk*h[k] SHALL be computed signed, at least WORD_SIZE_OUT+2 bits, with no intermediate truncation.
REQ-016 FSM states: RUN, FAULT; reset state RUN.
REQ-017 In RUN, a cycle with y_valid=1 is "accepted"; a cycle with y_valid=0 SHALL change no state, no history, no outputs except dropping x_valid to 0.
REQ-018 On an accepted sample, decode is valid iff r >= 0, r mod B0 == 0, and r/B0 <= 2^SAMPLE_SIZE-1.
REQ-019 Valid decode: next edge x_out <= r/B0, x_valid <= 1, h[1] <= r/B0, h[k] <= h[k-1] for k=2..6, x_count increments (saturating); latency exactly 1 clock from accepting edge to x_valid high.
REQ-020 Invalid decode: next edge err <= 1, state <= FAULT, x_valid stays 0, x_out and history hold, x_count holds.
REQ-021 In FAULT, y_valid SHALL be ignored; x_valid stays 0; err stays 1.
REQ-022 resync=1 (any state): next edge history <= 0, x_count <= 0, err <= 0, x_valid <= 0, x_out <= 0, state <= RUN.
REQ-023 resync and y_valid in the same cycle: resync wins, that y_in is discarded.
REQ-024 Back-to-back y_valid on consecutive cycles SHALL be accepted at full rate, one x_valid per y_valid, order preserved.
REQ-025 The combinational path from y_in/history to the x_out register SHALL fit one clock (no internal pipeline stage); history feedback of the newest sample SHALL be available for the immediately following accepted sample.

Reset
REQ-026 reset=1 at a rising edge SHALL force: x_out=0, x_valid=0, err=0, x_count=0, h[1..6]=0, state RUN; reset dominates resync and y_valid.
REQ-027 Reset asserted mid-stream SHALL discard all history; the next accepted sample is decoded against zero history.

Verification
REQ-028 Impulse: after reset, y_valid=1 with y_in=2,5,9,14,9,5,2,0 -> x_out=1,0,0,0,0,0,0,0, each x_valid one cycle later, err=0, x_count=8.
REQ-029 Constant full-scale: y_in=30,105,240,450,585,660,690,690 -> x_out=15 for all 8, err=0.
REQ-030 Non-divisible: after reset y_in=3 -> err=1 next cycle, x_valid=0, FAULT; further y_valid ignored; resync pulse -> err=0, x_count=0; then y_in=4 -> x_out=2.
REQ-031 Negative residual and overflow: y_in=2 then 4 -> x_out=1 then err=1 (r=-1); after resync, y_in=32 -> err=1 (r/B0=16>15).
REQ-032 Gaps and collisions: impulse sequence with y_valid low for 3 cycles between every sample -> identical x_out values as REQ-028; resync with y_valid=1 same cycle -> sample dropped, x_valid=0; reset during stream -> all outputs 0 next edge.
